// File: rtl/rand_arb_pkg.sv
// Shared types and constants for the LFSR-sharing random arbiter.
//   rand_arb_state_t : arbiter FSM state encoding
//   RAND_W           : width of the LFSR sample and of the returned value
//   max_t            : per-requester inclusive upper bound
package rand_arb_pkg;

  localparam int RAND_W = 4;

  typedef logic [RAND_W-1:0] max_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_RESP = 2'd2
  } rand_arb_state_t;

endpackage

// File: rtl/rand_arbiter_rr_picker.sv
// Combinational round-robin selector.
// Searches req starting at last_id+1 and wraps modulo N_REQ; the first set
// bit wins.
//   req     : in,  N_REQ  pending requests
//   last_id : in,  IDW    id granted most recently
//   grant   : out, N_REQ  one-hot winner (zero when nothing pending)
//   id      : out, IDW    index of the winner
//   any     : out, 1      at least one request pending
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last_id,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   id,
  output logic             any
);

  int             idx;
  logic [IDW-1:0] idx_w;

  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    idx   = 0;
    idx_w = '0;
    // Offsets 1..N_REQ so that last_id itself is checked last.
    for (int i = 1; i <= N_REQ; i++) begin
      idx   = (int'(last_id) + i) % N_REQ;
      idx_w = IDW'(idx);
      if (!any && req[idx_w]) begin
        any          = 1'b1;
        grant[idx_w] = 1'b1;
        id           = idx_w;
      end
    end
  end

endmodule

// File: rtl/rand_arbiter.sv
// Shares one free-running 4-bit LFSR between N_REQ requesters. Grants one
// requester at a time in round-robin order, draws LFSR samples until one is
// within [0, max] of that requester, and returns it with a one-cycle pulse.
// After MAX_TRIES rejected draws the latched max itself is returned.
//   i_clk        : in,  1        clock
//   i_rst_n      : in,  1        asynchronous active-low reset
//   i_req        : in,  N_REQ    request per requester, held until response
//   i_max        : in,  4*N_REQ  packed inclusive bounds, slice k = [4k+3:4k]
//   i_lfsr       : in,  4        current LFSR output
//   o_grant      : out, N_REQ    one-hot owner of the current draw
//   o_rand_valid : out, 1        response pulse
//   o_rand_id    : out, IDW      owner of the response
//   o_rand       : out, 4        random value
//
// state  | meaning
// S_IDLE | waiting for any request; picks next owner round-robin
// S_DRAW | sampling i_lfsr each cycle until accept or fallback
// S_RESP | valid pulse cycle; requests ignored, owner recorded as last_id
module rand_arbiter
  import rand_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_TRIES = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [RAND_W*N_REQ-1:0]   i_max,
  input  logic [RAND_W-1:0]         i_lfsr,
  output logic [N_REQ-1:0]          o_grant,
  output logic                      o_rand_valid,
  output logic [$clog2(N_REQ)-1:0]  o_rand_id,
  output logic [RAND_W-1:0]         o_rand
);

  localparam int IDW = $clog2(N_REQ);
  localparam int TW  = $clog2(MAX_TRIES + 1);

  rand_arb_state_t state_q, state_d;

  max_t           max_arr [N_REQ];
  max_t           max_q;
  logic [IDW-1:0] last_id_q;
  logic [TW-1:0]  try_q;

  logic [N_REQ-1:0] pick_grant;
  logic [IDW-1:0]   pick_id;
  logic             pick_any;

  logic do_grant, do_accept, do_reject, do_fallback, do_finish;

  for (genvar k = 0; k < N_REQ; k++) begin : g_max
    assign max_arr[k] = i_max[RAND_W*k +: RAND_W];
  end

  rr_picker #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_picker (
    .req     (i_req),
    .last_id (last_id_q),
    .grant   (pick_grant),
    .id      (pick_id),
    .any     (pick_any)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    do_grant    = 1'b0;
    do_accept   = 1'b0;
    do_reject   = 1'b0;
    do_fallback = 1'b0;
    do_finish   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          do_grant = 1'b1;
          state_d  = S_DRAW;
        end
      end
      S_DRAW: begin
        if (i_lfsr <= max_q) begin
          do_accept = 1'b1;
          state_d   = S_RESP;
        end else begin
          do_reject = 1'b1;
          // This rejection is the MAX_TRIES-th one.
          if (try_q == TW'(MAX_TRIES - 1)) begin
            do_fallback = 1'b1;
            state_d     = S_RESP;
          end
        end
      end
      S_RESP: begin
        do_finish = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_grant      <= '0;
      o_rand_valid <= 1'b0;
      o_rand_id    <= '0;
      o_rand       <= '0;
      max_q        <= '0;
      last_id_q    <= IDW'(N_REQ - 1);
      try_q        <= '0;
    end else begin
      if (do_grant) begin
        o_grant   <= pick_grant;
        o_rand_id <= pick_id;
        max_q     <= max_arr[pick_id];
        try_q     <= '0;
      end
      if (do_reject && try_q != TW'(MAX_TRIES)) begin
        try_q <= try_q + TW'(1);
      end
      if (do_accept) begin
        o_rand       <= i_lfsr;
        o_rand_valid <= 1'b1;
      end
      if (do_fallback) begin
        o_rand       <= max_q;
        o_rand_valid <= 1'b1;
      end
      if (do_finish) begin
        o_rand_valid <= 1'b0;
        o_grant      <= '0;
        last_id_q    <= o_rand_id;
      end
    end
  end

endmodule
